fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the PC adder / branch-target logic.
- Holds the PC register and drives the instruction-memory request/ready handshake. Selects the next PC, either sequential or from a redirect target computed in D.
- Loads the IF/ID pipeline register. Honours the one-instruction branch delay slot and hazard-unit stalls.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted for bubbles.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- stall  in  1  hazard unit: hold IF/ID and PC this cycle
- redirect_valid  in  1  D-stage branch/jump taken (qualified by hazard unit)
- redirect_pc  in  32  taken target (branch, j/jal, or jr)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc_f)
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr
- imem_rdata  in  32  instruction word
- pc_f  out  32  current fetch PC
- valid_d  out  1  IF/ID holds a real instruction
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc8_d  out  32  pc_d + 8, link value for jal/jalr
- exc_adel_d  out  1  fetch address error (optional feature)

Behaviour:
- Reset (reset==0 at clk edge):
  - pc_f=RESET_PC; state=FETCH; pend_valid=0; pend_pc=0; ibuf=0.
  - valid_d=0; instr_d=NOP_WORD; pc_d=RESET_PC; pc8_d=RESET_PC+8; exc_adel_d=0.
  - Reset has priority over all other inputs. Mid-wait reset drops the outstanding fetch and the pending redirect.
- States: FETCH (request outstanding), HOLD (instruction captured, ID stalled).
- FETCH:
  - imem_req=1; imem_addr=pc_f. Data returns combinationally in the same cycle imem_ready=1.
  - imem_ready=1, stall=0: IF/ID <= {1, imem_rdata, pc_f}; pc_f <= next_pc; stay FETCH.
  - imem_ready=1, stall=1: IF/ID unchanged; ibuf <= imem_rdata; goto HOLD; pc_f unchanged.
  - imem_ready=0, stall=0: IF/ID <= bubble {0, NOP_WORD, pc_d unchanged}; pc_f unchanged.
  - imem_ready=0, stall=1: everything held.
- HOLD:
  - imem_req=0.
  - stall=0: IF/ID <= {1, ibuf, pc_f}; pc_f <= next_pc; goto FETCH.
  - stall=1: remain HOLD.
- next_pc, in priority order:
  - pend_valid: pend_pc.
  - redirect_valid: redirect_pc.
  - otherwise: pc_f+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Delay slot: when redirect_valid is seen, the instruction at pc_f is the delay slot. It is always delivered, never flushed. The redirect is applied as next_pc at that instruction's delivery.
- Pending redirect:
  - If redirect_valid=1 in a cycle where no delivery happens (FETCH without ready, FETCH+stall, or HOLD+stall): pend_valid <= 1, pend_pc <= redirect_pc.
  - pend_valid clears on the delivery that consumes it.
  - A redirect_valid arriving while pend_valid=1 is illegal (branch in delay slot). Pending wins; the new request is dropped.
- redirect_valid is ignored while stall=1 and pend_valid=0 only if it is deasserted later. The hazard unit guarantees it is held with the branch in D.
- pc8_d is always pc_d+8, registered with pc_d.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - If pc_f[1:0]!=0 when an instruction would be delivered, IF/ID loads {1, NOP_WORD, pc_f} with exc_adel_d=1.
  - imem_req is not asserted for the misaligned address; delivery proceeds as if imem_ready=1.
  - exc_adel_d clears on the next IF/ID load.
- Not defined: exc_adel_d tied 0; no alignment logic; pc_f[1:0] passed through unchecked.

Test Plan:
- Reset release, imem_ready=1 constant, stall=0 → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles. pc_d lags by one cycle; valid_d=1 from the 2nd cycle; pc8_d=0x3008 when pc_d=0x3000.
- Branch in D at cycle t, redirect_valid=1, redirect_pc=0x3040, with pc_f=0x3008 → 0x3008 delivered (delay slot), next pc_f=0x3040, no bubble.
- imem_ready=0 for 3 cycles at pc_f=0x3010, stall=0 → three bubbles (valid_d=0, instr_d=0), pc_f stays 0x3010. Then 0x3010 is delivered.
- Redirect to 0x3100 during an imem wait → pend_valid=1. When the delay slot delivers, pc_f=0x3100 and pend_valid=0.
- stall=1 for 2 cycles as 0x3020 returns → state HOLD, imem_req=0, IF/ID unchanged. On stall release: instr_d=buffered word, pc_d=0x3020.
- With FETCH_ALIGN_CHK_EN: redirect_pc=0x3042 → delay slot normal, then IF/ID gets exc_adel_d=1, pc_d=0x3042, instr_d=0.
- Without FETCH_ALIGN_CHK_EN: exc_adel_d stays 0 for the same stimulus.
- reset=0 asserted mid-HOLD → pc_f=0x3000, valid_d=0, pend_valid=0 next cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC register, imem handshake, IF/ID register, delay-slot redirect.
// Optional fetch address alignment check enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  fetch_unit_if.master  imem,
  output logic [31:0]   pc_f,
  output logic          valid_d,
  output logic [31:0]   instr_d,
  output logic [31:0]   pc_d,
  output logic [31:0]   pc8_d,
  output logic          exc_adel_d
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_next;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] ibuf;
  logic [31:0] next_pc;
  logic [31:0] deliver_word;
  logic [31:0] capture_word;
  logic        deliver, capture, bubble;
  logic        misaligned;
  logic        fetch_ok;

`ifdef FETCH_ALIGN_CHK_EN
  assign misaligned = (pc_f[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned fetch never reaches imem; it completes at once as an exception bubble.
  assign fetch_ok     = imem.imem_ready | misaligned;
  assign capture_word = misaligned ? NOP_WORD : imem.imem_rdata;

  always_comb begin
    if (pend_valid)          next_pc = pend_pc;
    else if (redirect_valid) next_pc = redirect_pc;
    else                     next_pc = pc_f + 32'd4;
  end

  always_comb begin
    state_next    = state;
    imem.imem_req = 1'b0;
    deliver       = 1'b0;
    capture       = 1'b0;
    bubble        = 1'b0;
    deliver_word  = ibuf;
    case (state)
      FETCH: begin
        imem.imem_req = ~misaligned;
        if (fetch_ok) begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_word = capture_word;
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          deliver      = 1'b1;
          deliver_word = ibuf;
          state_next   = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign imem.imem_addr = pc_f;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      pc_f       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      ibuf       <= '0;
      valid_d    <= 1'b0;
      instr_d    <= NOP_WORD;
      pc_d       <= RESET_PC;
      pc8_d      <= RESET_PC + 32'd8;
    end else begin
      state <= state_next;
      if (capture) ibuf <= capture_word;
      if (deliver) begin
        valid_d    <= 1'b1;
        instr_d    <= deliver_word;
        pc_d       <= pc_f;
        pc8_d      <= pc_f + 32'd8;
        pc_f       <= next_pc;
        pend_valid <= 1'b0;
      end else begin
        if (bubble) begin
          valid_d <= 1'b0;
          instr_d <= NOP_WORD;
        end
        // Redirect seen without a delivery is remembered; a second one while pending is dropped.
        if (redirect_valid && !pend_valid) begin
          pend_valid <= 1'b1;
          pend_pc    <= redirect_pc;
        end
      end
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!reset)       exc_adel_d <= 1'b0;
    else if (deliver) exc_adel_d <= misaligned;
    else if (bubble)  exc_adel_d <= 1'b0;
  end
`else
  assign exc_adel_d = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem returns ~address so every word is predictable.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] pc_f, instr_d, pc_d, pc8_d;
  logic        valid_d, exc_adel_d;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  fetch_unit_if mif ();
  assign mif.imem_ready = ready;
  assign mif.imem_rdata = ~mif.imem_addr;

  fetch_unit #(.RESET_PC(32'h0000_3000), .NOP_WORD(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (mif.master),
    .pc_f           (pc_f),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc8_d          (pc8_d),
    .exc_adel_d     (exc_adel_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [31:0] nxt);
    check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, v});
    check({tag, ".instr_d"}, instr_d, ins);
    check({tag, ".pc_d"},    pc_d, pc);
    check({tag, ".pc8_d"},   pc8_d, pc + 32'd8);
    check({tag, ".pc_f"},    pc_f, nxt);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ready = 1'b1;
    step(); step();
    check_ifid("reset", 1'b0, 32'h0, 32'h3000, 32'h3000);
    check("reset.exc", {31'd0, exc_adel_d}, 32'd0);
    check("reset.req", {31'd0, mif.imem_req}, 32'd1);
    check("reset.addr", mif.imem_addr, 32'h3000);

    // Sequential streaming
    reset = 1'b1;
    step(); check_ifid("seq0", 1'b1, 32'hFFFF_CFFF, 32'h3000, 32'h3004);
    step(); check_ifid("seq1", 1'b1, 32'hFFFF_CFFB, 32'h3004, 32'h3008);

    // Redirect in D: 0x3008 is the delay slot, no bubble
    redirect_valid = 1'b1; redirect_pc = 32'h3040;
    step(); check_ifid("br_slot", 1'b1, 32'hFFFF_CFF7, 32'h3008, 32'h3040);
    redirect_valid = 1'b0;
    step(); check_ifid("br_tgt", 1'b1, 32'hFFFF_CFBF, 32'h3040, 32'h3044);

    // imem wait: three bubbles, PC held
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_ifid("wait", 1'b0, 32'h0, 32'h3040, 32'h3044);
      check("wait.req", {31'd0, mif.imem_req}, 32'd1);
    end
    ready = 1'b1;
    step(); check_ifid("wait_done", 1'b1, 32'hFFFF_CFBB, 32'h3044, 32'h3048);

    // Redirect during imem wait becomes pending
    ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3100;
    step(); check_ifid("pend_set", 1'b0, 32'h0, 32'h3044, 32'h3048);
    redirect_valid = 1'b0;
    step(); check_ifid("pend_wait", 1'b0, 32'h0, 32'h3044, 32'h3048);
    ready = 1'b1;
    step(); check_ifid("pend_slot", 1'b1, 32'hFFFF_CFB7, 32'h3048, 32'h3100);
    step(); check_ifid("pend_clr", 1'b1, 32'hFFFF_CEFF, 32'h3100, 32'h3104);

    // Stall as the word returns: HOLD, IF/ID frozen, word buffered
    stall = 1'b1;
    step(); check_ifid("hold0", 1'b1, 32'hFFFF_CEFF, 32'h3100, 32'h3104);
    check("hold0.req", {31'd0, mif.imem_req}, 32'd0);
    ready = 1'b0;
    step(); check_ifid("hold1", 1'b1, 32'hFFFF_CEFF, 32'h3100, 32'h3104);
    check("hold1.req", {31'd0, mif.imem_req}, 32'd0);
    stall = 1'b0;
    step(); check_ifid("hold_rel", 1'b1, 32'hFFFF_CEFB, 32'h3104, 32'h3108);
    check("hold_rel.req", {31'd0, mif.imem_req}, 32'd1);

    // Redirect while HOLD+stall goes pending, applied at the buffered delivery
    ready = 1'b1; stall = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h3200;
    step(); check_ifid("hold_br", 1'b1, 32'hFFFF_CEFB, 32'h3104, 32'h3108);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check_ifid("hold_br_slot", 1'b1, 32'hFFFF_CEF7, 32'h3108, 32'h3200);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h3042;
    step(); check_ifid("mis_slot", 1'b1, 32'hFFFF_CDFF, 32'h3200, 32'h3042);
    check("mis_slot.exc", {31'd0, exc_adel_d}, 32'd0);
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    check("mis.req", {31'd0, mif.imem_req}, 32'd0);
    step(); check_ifid("mis_tgt", 1'b1, 32'h0, 32'h3042, 32'h3046);
    check("mis_tgt.exc", {31'd0, exc_adel_d}, 32'd1);
`else
    check("mis.req", {31'd0, mif.imem_req}, 32'd1);
    step(); check_ifid("mis_tgt", 1'b1, 32'hFFFF_CFBD, 32'h3042, 32'h3046);
    check("mis_tgt.exc", {31'd0, exc_adel_d}, 32'd0);
`endif

    // PC wrap: 0xFFFF_FFFC + 4 -> 0, link value wraps too
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_slot.pc_f", pc_f, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step(); check_ifid("wrap", 1'b1, 32'h0000_0003, 32'hFFFF_FFFC, 32'h0000_0000);
    check("wrap.exc", {31'd0, exc_adel_d}, 32'd0);

    // Reset mid-HOLD with a pending redirect: both dropped
    stall = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    step();
    reset = 1'b0;
    step(); check_ifid("rst_hold", 1'b0, 32'h0, 32'h3000, 32'h3000);
    check("rst_hold.req", {31'd0, mif.imem_req}, 32'd1);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    step(); check_ifid("rst_resume", 1'b1, 32'hFFFF_CFFF, 32'h3000, 32'h3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
